// File: rtl/reg_dump_unit.sv
// Debug dump engine: walks every register of the register file through its read port
// and streams each value, plus an optional XOR checksum beat, over a valid/ready link.
module reg_dump_unit #(
  parameter int NUM_REGS    = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter bit APPEND_CSUM = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  output logic              rf_sel,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_csum;
  logic [DATA_W-1:0] r_outData;
  logic [ADDR_W-1:0] r_outAddr;
  logic              r_outLast;
  logic              r_outValid;
  logic              r_rfSel;
  logic              r_busy;
  logic              r_done;

  logic w_active;
  logic w_flush;
  logic w_handshake;
  logic w_lastIdx;

  assign w_active    = (r_state == READ) || (r_state == SEND) || (r_state == CSUM);
  assign w_flush     = RESET || (abort && w_active);
  assign w_handshake = r_outValid && out_ready;
  assign w_lastIdx   = (r_idx == LAST_IDX);

  // Abort shares the reset path: a beat handshaken in the abort cycle is discarded.
  always_ff @(posedge CLK) begin
    if (w_flush) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_csum     <= '0;
      r_outData  <= '0;
      r_outAddr  <= '0;
      r_outLast  <= 1'b0;
      r_outValid <= 1'b0;
      r_rfSel    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= READ;
            r_idx   <= '0;
            r_csum  <= '0;
            r_rfSel <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        READ: begin
          r_outData  <= rf_data;
          r_outAddr  <= r_idx;
          r_csum     <= r_csum ^ rf_data;
          r_outLast  <= w_lastIdx && !APPEND_CSUM;
          r_outValid <= 1'b1;
          r_state    <= SEND;
        end
        SEND: begin
          if (w_handshake) begin
            if (!w_lastIdx) begin
              r_idx      <= r_idx + 1'b1;
              r_outValid <= 1'b0;
              r_state    <= READ;
            end else if (APPEND_CSUM) begin
              r_outData  <= r_csum;
              r_outAddr  <= '0;
              r_outLast  <= 1'b1;
              r_outValid <= 1'b1;
              r_state    <= CSUM;
            end else begin
              r_outData  <= '0;
              r_outAddr  <= '0;
              r_outLast  <= 1'b0;
              r_outValid <= 1'b0;
              r_rfSel    <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        CSUM: begin
          if (w_handshake) begin
            r_outData  <= '0;
            r_outAddr  <= '0;
            r_outLast  <= 1'b0;
            r_outValid <= 1'b0;
            r_rfSel    <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_csum  <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rf_sel    = r_rfSel;
  assign rf_addr   = r_idx;
  assign out_data  = r_outData;
  assign out_addr  = r_outAddr;
  assign out_last  = r_outLast;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench: one dumper with the checksum beat and one without, both fed from
// a shared register-file model; captured beat streams are compared against an expected list.
module tb_reg_dump_unit;

  typedef logic [12:0] beat_t;
  typedef beat_t beatq_t[$];

  typedef struct {
    string      name;
    int         fill;
    logic [7:0] val;
    int         readyMode;
    bit         noise;
    int         pokeAddr;
    logic [7:0] expCsum;
    int         expDoneA;
    int         expDoneB;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic       abort;
  logic       out_ready;
  logic [7:0] regs [16];

  logic       rfSel    [2];
  logic [3:0] rfAddr   [2];
  logic [7:0] rfData   [2];
  logic [7:0] outData  [2];
  logic [3:0] outAddr  [2];
  logic       outLast  [2];
  logic       outValid [2];
  logic       busy     [2];
  logic       done     [2];

  int passCnt  = 0;
  int totalCnt = 0;

  int         firstVal [2];
  int         doneCnt  [2];
  int         doneCyc  [2];
  int         lastHs   [2];
  int         stabErr  [2];
  int         selErr   [2];
  int         extraErr [2];
  logic       hold     [2];
  logic [7:0] hData    [2];
  logic [3:0] hAddr    [2];
  beatq_t     capA;
  beatq_t     capB;

  vec_t vecs [4];

  always #5 CLK = ~CLK;

  assign rfData[0] = regs[rfAddr[0]];
  assign rfData[1] = regs[rfAddr[1]];

  reg_dump_unit #(.APPEND_CSUM(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .rf_sel(rfSel[0]), .rf_addr(rfAddr[0]), .rf_data(rfData[0]),
    .out_data(outData[0]), .out_addr(outAddr[0]), .out_last(outLast[0]),
    .out_valid(outValid[0]), .out_ready(out_ready), .busy(busy[0]), .done(done[0])
  );

  reg_dump_unit #(.APPEND_CSUM(1'b0)) dutNoCsum (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .rf_sel(rfSel[1]), .rf_addr(rfAddr[1]), .rf_data(rfData[1]),
    .out_data(outData[1]), .out_addr(outAddr[1]), .out_last(outLast[1]),
    .out_valid(outValid[1]), .out_ready(out_ready), .busy(busy[1]), .done(done[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mkBeat(input logic last, input logic [3:0] addr, input logic [7:0] data);
    return {last, addr, data};
  endfunction

  // Expected stream: every register in index order, then the XOR of them all if enabled.
  function automatic beatq_t buildExpected(input bit withCsum);
    beatq_t     q;
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      q.push_back(mkBeat(!withCsum && (i == 15), 4'(i), regs[i]));
      x = x ^ regs[i];
    end
    if (withCsum) q.push_back(mkBeat(1'b1, 4'h0, x));
    return q;
  endfunction

  function automatic logic [7:0] modelCsum();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 16; i++) x = x ^ regs[i];
    return x;
  endfunction

  task automatic compareBeats(input string tag, input beatq_t act, input beatq_t exp);
    int n;
    checkOutput($sformatf("%s beat count", tag), act.size(), exp.size());
    n = (act.size() < exp.size()) ? act.size() : exp.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s beat%0d {last,addr,data}", tag, i), 32'(act[i]), 32'(exp[i]));
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("%s outputs dut%0d", tag, d),
                  {13'd0, rfSel[d], rfAddr[d], outData[d], outAddr[d], outLast[d],
                   outValid[d], busy[d], done[d]}, 32'd0);
  endtask

  // Runs one dump from the start pulse to both done pulses; cycle c=1 is the cycle after the start edge.
  task automatic applyStimulus(input string tag, input int readyMode, input bit noise,
                               input int pokeAddr, input logic [7:0] pokeVal,
                               input logic [7:0] expCsum, input int expDoneA, input int expDoneB);
    beatq_t expA;
    beatq_t expB;
    beat_t  lb;
    int     c;
    expA = buildExpected(1'b1);
    expB = buildExpected(1'b0);
    capA.delete();
    capB.delete();
    for (int d = 0; d < 2; d++) begin
      firstVal[d] = 0; doneCnt[d] = 0; doneCyc[d] = 0; lastHs[d] = 0;
      stabErr[d] = 0; selErr[d] = 0; extraErr[d] = 0; hold[d] = 1'b0;
    end
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int n = 0; n < 1000 && !(doneCnt[0] > 0 && doneCnt[1] > 0); n++) begin
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = noise && (n >= 2) && (n <= 20) && (n % 4 == 0);
      @(negedge CLK);
      c = n + 1;
      for (int d = 0; d < 2; d++) begin
        if (outValid[d] && firstVal[d] == 0) firstVal[d] = c;
        if (hold[d] && (!outValid[d] || outData[d] != hData[d] || outAddr[d] != hAddr[d]))
          stabErr[d]++;
        hold[d]  = outValid[d] && !out_ready;
        hData[d] = outData[d];
        hAddr[d] = outAddr[d];
        if (outValid[d] && out_ready) begin
          lastHs[d] = c;
          if (d == 0) capA.push_back(mkBeat(outLast[d], outAddr[d], outData[d]));
          else        capB.push_back(mkBeat(outLast[d], outAddr[d], outData[d]));
        end
        if (rfSel[d] !== (busy[d] && !done[d])) selErr[d]++;
        if (done[d]) begin
          doneCnt[d]++;
          doneCyc[d] = c;
        end
      end
      if (pokeAddr >= 0 && outValid[0] && outAddr[0] == 4'(pokeAddr)) regs[pokeAddr] = pokeVal;
      @(posedge CLK);
      #1;
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_ready = 1'b0;
      @(negedge CLK);
      for (int d = 0; d < 2; d++) if (busy[d] || done[d]) extraErr[d]++;
      @(posedge CLK);
      #1;
    end
    compareBeats({tag, " csum"}, capA, expA);
    compareBeats({tag, " nocsum"}, capB, expB);
    if (capA.size() > 0) begin
      lb = capA[capA.size() - 1];
      checkOutput({tag, " checksum value"}, 32'(lb[7:0]), 32'(expCsum));
    end
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d done pulses", tag, d), doneCnt[d], 1);
      checkOutput($sformatf("%s dut%0d first valid cycle", tag, d), firstVal[d], 2);
      checkOutput($sformatf("%s dut%0d unstable held beats", tag, d), stabErr[d], 0);
      checkOutput($sformatf("%s dut%0d rf_sel violations", tag, d), selErr[d], 0);
      checkOutput($sformatf("%s dut%0d activity after done", tag, d), extraErr[d], 0);
    end
    if (expDoneA > 0) checkOutput({tag, " csum done cycle"}, doneCyc[0], expDoneA);
    if (expDoneB > 0) checkOutput({tag, " nocsum done cycle"}, doneCyc[1], expDoneB);
    checkOutput({tag, " nocsum done after last handshake"}, doneCyc[1], lastHs[1] + 1);
  endtask

  task automatic fillRegs(input int fill, input logic [7:0] val);
    for (int i = 0; i < 16; i++)
      regs[i] = (fill == 0) ? val + 8'(i) : ((i == 15) ? val : 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    RESET = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    fillRegs(0, 8'h10);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkAllZero("reset");
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Full dump with ready high: 16x(READ,SEND) + CSUM + DONE puts done in cycle 34.
    vecs[0] = '{"ramp_ready", 0, 8'h10, 0, 1'b0, -1, 8'h00, 34, 33};
    vecs[1] = '{"ramp_1of3",  0, 8'h10, 1, 1'b0, -1, 8'h00, 0, 0};
    vecs[2] = '{"poke_r3",    1, 8'hA5, 0, 1'b0, 3,  8'hA5, 34, 33};
    vecs[3] = '{"start_noise",0, 8'h40, 2, 1'b1, -1, 8'h00, 0, 0};
    for (int v = 0; v < 4; v++) begin
      fillRegs(vecs[v].fill, vecs[v].val);
      applyStimulus(vecs[v].name, vecs[v].readyMode, vecs[v].noise, vecs[v].pokeAddr, 8'hFF,
                    vecs[v].expCsum, vecs[v].expDoneA, vecs[v].expDoneB);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
      applyStimulus($sformatf("random%0d", r), 2, 1'($urandom_range(0, 1)), -1, 8'h00,
                    modelCsum(), 0, 0);
    end

    // Abort coincident with a handshake in SEND of r7.
    fillRegs(0, 8'h10);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (outValid[0] && outAddr[0] == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort reached SEND r7", 32'(found), 32'd1);
    abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    @(negedge CLK);
    checkAllZero("after abort");
    doneCnt[0] = 0; doneCnt[1] = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) if (done[d]) doneCnt[d]++;
    end
    checkOutput("abort no done csum", doneCnt[0], 0);
    checkOutput("abort no done nocsum", doneCnt[1], 0);
    @(posedge CLK);
    #1;
    applyStimulus("after_abort", 0, 1'b0, -1, 8'h00, 8'h00, 34, 33);

    // Reset while the checksum beat is pending.
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge CLK);
    #1 begin
      start = 1'b0;
      out_ready = 1'b1;
    end
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (outValid[0] && outLast[0]) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reset reached CSUM", 32'(found), 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checkAllZero("reset in CSUM");
    doneCnt[0] = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (done[0] || busy[0]) doneCnt[0]++;
    end
    checkOutput("reset no done or busy", doneCnt[0], 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
